// File: rtl/instream_pkg.sv
// Shared definitions for the instream bank: channel FSM states and default sizing.
package instream_pkg;

   localparam int NCH_DEFAULT   = 4;
   localparam int DEPTH_DEFAULT = 39;
   localparam int W_DEFAULT     = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chanState_t;

endpackage

// File: rtl/instream_chan.sv
// One stream channel: replays its slice of the data table word by word under
// ready/valid handshaking, optionally looping.
module instream_chan
   import instream_pkg::*;
#(
   parameter int DEPTH     = DEPTH_DEFAULT,
   parameter int W         = W_DEFAULT,
   parameter int AUTOSTART = 1,
   parameter int LW        = $clog2(DEPTH + 1)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LW-1:0]           length,
   input  logic [DEPTH-1:0][W-1:0] data,
   input  logic                    loop_en,
   input  logic                    start,
   input  logic                    wready,
   output logic                    write,
   output logic [W-1:0]            out,
   output logic                    done
);

   chanState_t    state, stateNext;
   logic [LW-1:0] idx, idxNext;
   logic [LW-1:0] len, lenNext;
   logic [LW-1:0] lenClamp;
   logic [W-1:0]  outNext;
   logic          writeNext, doneNext;
   logic          autoPending, takeStart;

   // autoPending fakes a start pulse on the first cycle out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         len         <= '0;
         write       <= 1'b0;
         out         <= '0;
         done        <= 1'b0;
         autoPending <= (AUTOSTART != 0);
      end else begin
         state       <= stateNext;
         idx         <= idxNext;
         len         <= lenNext;
         write       <= writeNext;
         out         <= outNext;
         done        <= doneNext;
         autoPending <= 1'b0;
      end
   end

   // out is preloaded with the word the next cycle will present
   always_comb begin
      stateNext = state;
      idxNext   = idx;
      lenNext   = len;
      writeNext = write;
      outNext   = out;
      doneNext  = done;
      lenClamp  = (length > LW'(DEPTH)) ? LW'(DEPTH) : length;
      takeStart = start | autoPending;

      case (state)
         IDLE, DONE: begin
            if (takeStart) begin
               lenNext = lenClamp;
               idxNext = '0;
               if (lenClamp == '0) begin
                  stateNext = DONE;
                  writeNext = 1'b0;
                  doneNext  = 1'b1;
               end else begin
                  stateNext = RUN;
                  writeNext = 1'b1;
                  doneNext  = 1'b0;
                  outNext   = data[0];
               end
            end
         end
         RUN: begin
            if (wready) begin
               if (idx == len - LW'(1)) begin
                  if (loop_en) begin
                     idxNext = '0;
                     outNext = data[0];
                  end else begin
                     stateNext = DONE;
                     writeNext = 1'b0;
                     doneNext  = 1'b1;
                  end
               end else begin
                  idxNext = idx + LW'(1);
                  outNext = data[idx + LW'(1)];
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: rtl/instream_bank.sv
// Bank of independent stream channels, each replaying its own slice of a shared data table.
module instream_bank
   import instream_pkg::*;
#(
   parameter int NCH       = NCH_DEFAULT,
   parameter int DEPTH     = DEPTH_DEFAULT,
   parameter int W         = W_DEFAULT,
   parameter int AUTOSTART = 1
)(
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NCH-1:0][$clog2(DEPTH+1)-1:0]       length,
   input  logic signed [NCH*DEPTH-1:0][W-1:0]        data,
   input  logic [NCH-1:0]                            loop_en,
   input  logic [NCH-1:0]                            start,
   input  logic [NCH-1:0]                            wready,
   output logic [NCH-1:0]                            write,
   output logic [NCH-1:0][W-1:0]                     out,
   output logic [NCH-1:0]                            done
);

   for (genvar c = 0; c < NCH; c++) begin : gChan
      instream_chan #(
         .DEPTH     (DEPTH),
         .W         (W),
         .AUTOSTART (AUTOSTART)
      ) uChan (
         .clk     (clk),
         .rst     (rst),
         .length  (length[c]),
         .data    (data[c*DEPTH +: DEPTH]),
         .loop_en (loop_en[c]),
         .start   (start[c]),
         .wready  (wready[c]),
         .write   (write[c]),
         .out     (out[c]),
         .done    (done[c])
      );
   end

endmodule

// File: tb/tb_instream_bank.sv
// Scoreboard bench for instream_bank: stimulus pushes expected words per channel,
// a negedge monitor pops and compares on every handshake.
module tb_instream_bank;

   localparam int NCH   = 4;
   localparam int DEPTH = 39;
   localparam int W     = 11;
   localparam int LW    = $clog2(DEPTH + 1);

   logic                            clk = 1'b0;
   logic                            rst;
   logic [NCH-1:0][LW-1:0]          length;
   logic signed [NCH*DEPTH-1:0][W-1:0] data;
   logic [NCH-1:0]                  loop_en, start, wready;
   logic [NCH-1:0]                  write, done;
   logic [NCH-1:0][W-1:0]           out;

   int expQ [NCH][$];
   int xferCount [NCH];
   int total = 0;
   int bad   = 0;
   logic [NCH-1:0] rdyTable [10];

   always #5 clk = ~clk;

   instream_bank #(
      .NCH       (NCH),
      .DEPTH     (DEPTH),
      .W         (W),
      .AUTOSTART (1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .length  (length),
      .data    (data),
      .loop_en (loop_en),
      .start   (start),
      .wready  (wready),
      .write   (write),
      .out     (out),
      .done    (done)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   task automatic setWord(input int c, input int i, input int v);
      data[c*DEPTH + i] = W'(v);
   endtask

   // start is a one-cycle pulse; wready holds for the whole call
   task automatic applyStimulus(input logic [NCH-1:0] st, input logic [NCH-1:0] rdy, input int cycles);
      start  = st;
      wready = rdy;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         start = '0;
      end
   endtask

   // A handshake seen here completes on the following rising edge, unless reset intervenes
   always @(negedge clk) begin
      int e;
      if (!rst) begin
         for (int c = 0; c < NCH; c++) begin
            if (write[c] && wready[c]) begin
               xferCount[c]++;
               if (expQ[c].size() == 0) begin
                  checkOutput($sformatf("spurious_xfer_ch%0d", c), expQ[c].size(), 1);
               end else begin
                  e = expQ[c].pop_front();
                  checkOutput($sformatf("word_ch%0d", c), int'($signed(out[c])), e);
               end
            end
         end
      end
   end

   initial begin
      rst     = 1'b1;
      start   = '0;
      wready  = '0;
      loop_en = '0;
      data    = '0;
      length  = '0;
      for (int c = 0; c < NCH; c++) xferCount[c] = 0;

      length[0] = LW'(3);
      length[1] = LW'(4);
      length[2] = LW'(2);
      length[3] = LW'(0);
      loop_en   = 4'b0100;
      setWord(0, 0, 5);  setWord(0, 1, -2); setWord(0, 2, 7);
      setWord(1, 0, 10); setWord(1, 1, 11); setWord(1, 2, 12); setWord(1, 3, 13);
      setWord(2, 0, 1);  setWord(2, 1, 2);
      expQ[0].push_back(5);  expQ[0].push_back(-2); expQ[0].push_back(7);
      for (int i = 0; i < 4; i++) expQ[1].push_back(10 + i);
      for (int i = 0; i < 5; i++) expQ[2].push_back((i % 2) + 1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_write", int'(write), 0);
      checkOutput("reset_done", int'(done), 0);
      for (int c = 0; c < NCH; c++) checkOutput($sformatf("reset_out_ch%0d", c), int'(out[c]), 0);

      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("autostart_write", int'(write), 4'b0111);
      checkOutput("autostart_done", int'(done), 4'b1000);

      // ch0 streams freely, ch1 stalls in a pattern, ch2 loops then stalls on its second word
      rdyTable = '{4'b1111, 4'b0101, 4'b1101, 4'b0111, 4'b0101,
                   4'b1011, 4'b0001, 4'b1011, 4'b0011, 4'b0011};
      for (int k = 0; k < 10; k++) applyStimulus('0, rdyTable[k], 1);
      checkOutput("phase1_write", int'(write), 4'b0100);
      checkOutput("phase1_done", int'(done), 4'b1011);
      checkOutput("loop_stall_out", int'($signed(out[2])), 2);
      for (int c = 0; c < NCH; c++) checkOutput($sformatf("phase1_empty_ch%0d", c), expQ[c].size(), 0);

      // start during RUN must not restart ch2 with the new length
      length[2] = LW'(3);
      applyStimulus(4'b0100, 4'b0000, 1);
      checkOutput("ignored_start_write", int'(write), 4'b0100);
      checkOutput("ignored_start_out", int'($signed(out[2])), 2);
      loop_en[2] = 1'b0;
      expQ[2].push_back(2);
      applyStimulus('0, 4'b0100, 3);
      checkOutput("ch2_done", int'(done[2]), 1);
      checkOutput("ch2_write", int'(write[2]), 0);

      // oversize length clamps to DEPTH
      for (int i = 0; i < DEPTH; i++) begin
         setWord(1, i, 100 + i);
         expQ[1].push_back(100 + i);
      end
      length[1]    = LW'(50);
      xferCount[1] = 0;
      applyStimulus(4'b0010, 4'b0010, 1);
      applyStimulus('0, 4'b0010, 42);
      checkOutput("clamp_xfers", xferCount[1], DEPTH);
      checkOutput("clamp_done", int'(done[1]), 1);
      checkOutput("clamp_write", int'(write[1]), 0);

      // reset after two of five transfers
      length[0] = LW'(5);
      setWord(0, 0, 5); setWord(0, 1, -2); setWord(0, 2, 7); setWord(0, 3, 20); setWord(0, 4, -30);
      expQ[0].push_back(5); expQ[0].push_back(-2);
      applyStimulus(4'b0001, 4'b0001, 3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_write", int'(write), 0);
      checkOutput("midrst_done", int'(done), 0);
      checkOutput("midrst_empty", expQ[0].size(), 0);
      expQ[0].push_back(5); expQ[0].push_back(-2); expQ[0].push_back(7);
      expQ[0].push_back(20); expQ[0].push_back(-30);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("restart_write", int'(write[0]), 1);
      applyStimulus('0, 4'b0001, 7);
      checkOutput("restart_done", int'(done[0]), 1);
      checkOutput("restart_empty", expQ[0].size(), 0);

      // all channels concurrently under random backpressure
      rst = 1'b1;
      wready = '0;
      loop_en = '0;
      for (int c = 0; c < NCH; c++) begin
         length[c] = LW'(4 + c);
         for (int i = 0; i < 4 + c; i++) begin
            setWord(c, i, c*50 + i*3 - 20);
            expQ[c].push_back(c*50 + i*3 - 20);
         end
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) xferCount[c] = 0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 60; k++)
         applyStimulus((k == 2) ? {NCH{1'b1}} : {NCH{1'b0}}, NCH'($urandom_range(0, (1 << NCH) - 1)), 1);
      applyStimulus('0, {NCH{1'b1}}, 12);
      for (int c = 0; c < NCH; c++) begin
         checkOutput($sformatf("rand_xfers_ch%0d", c), xferCount[c], 4 + c);
         checkOutput($sformatf("rand_empty_ch%0d", c), expQ[c].size(), 0);
      end
      checkOutput("rand_done", int'(done), 4'b1111);
      checkOutput("rand_write", int'(write), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instream_bank.md
INSTREAM_BANK -- requirements
Module: instream_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent stream channels.
REQ-002 SHALL have parameter DEPTH, default 39, maximum words stored per channel.
REQ-003 SHALL have parameter W, default 11, signed data word width.
REQ-004 SHALL have parameter AUTOSTART, default 1; 1 = every channel enters RUN on the first cycle after reset without a start pulse.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port length  input  NCH x LW, where LW=$clog2(DEPTH+1)  words to emit per channel, sampled at start.
REQ-008 SHALL have port data  input  NCH*DEPTH x W signed  channel c owns elements c*DEPTH .. c*DEPTH+DEPTH-1, in emission order.
REQ-009 SHALL have port loop_en  input  NCH  per channel: 1 = restart at element 0 after the last word instead of stopping.
REQ-010 SHALL have port start  input  NCH  per-channel single-cycle start request.
REQ-011 SHALL have port wready  input  NCH  per-channel downstream ready.
REQ-012 SHALL have port write  output  NCH  per-channel word-valid, registered.
REQ-013 SHALL have port out  output  NCH x W  per-channel current word, registered.
REQ-014 SHALL have port done  output  NCH  per-channel stream-complete flag, registered.

Function
REQ-015 Each channel SHALL run a three-state FSM: IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start[c]=1 SHALL latch len=min(length[c],DEPTH), clear idx to 0, clear done, and go to RUN, or to DONE if len=0.
REQ-017 In RUN, write[c] SHALL be 1 and out[c] SHALL equal data[c*DEPTH+idx].
REQ-018 A transfer SHALL occur only in a cycle where write[c]=1 and wready[c]=1; out and write SHALL hold stable while wready[c]=0.
REQ-019 After a transfer with idx<len-1, the next cycle SHALL present idx+1, sustaining one word per cycle when wready stays high.
REQ-020 After a transfer with idx=len-1: with loop_en[c]=1, idx SHALL wrap to 0 and the channel SHALL stay in RUN; otherwise the channel SHALL go to DONE, with write=0 and done=1 on the next cycle.
REQ-021 start[c] SHALL be ignored while in RUN.
REQ-022 Latency from start[c] sampled at edge t to write[c]=1 SHALL be one cycle (valid after edge t+1).
REQ-023 Changes to length or data during RUN SHALL not alter len; data SHALL be read live, and the source SHALL hold it stable while the channel is in RUN.
REQ-024 Channels SHALL be fully independent, with no cross-channel ordering or arbitration.

Reset
REQ-025 While rst=1, every channel SHALL have write=0, out=0, done=0, idx=0 and state IDLE.
REQ-026 Reset asserted mid-stream SHALL abort the stream with no further transfer; a wready high in that cycle SHALL not count as a transfer.
REQ-027 With AUTOSTART=1, the first cycle after rst falls SHALL behave as if start were high on every channel, sampling length at that edge.

Structure
REQ-028 Package instream_pkg SHALL hold the FSM state enum and the default values of NCH, DEPTH and W.
REQ-029 Sub-module instream_chan SHALL implement one channel (FSM, idx, len, out register), instantiated NCH times by a generate loop in instream_bank.
REQ-030 Implementation SHALL target 120-400 lines of RTL in total.

Verification
REQ-031 AUTOSTART=1, length[0]=3, data 5,-2,7, wready held 1 -> out 5,-2,7 on consecutive cycles, then write=0, done=1.
REQ-032 length=4, wready toggling 1,0,0,1,... -> every word emitted exactly once, out stable during stalls, 4 transfers total.
REQ-033 loop_en=1, length=2, data 1,2, wready=1 for 6 cycles -> out 1,2,1,2,1,2 and done stays 0.
REQ-034 length=0 with start -> write never asserts, done=1 one cycle after start; length=50 with DEPTH=39 -> exactly 39 transfers.
REQ-035 rst pulsed after 2 of 5 transfers -> write=0 on the next cycle, then a restart emits from element 0.
REQ-036 NCH=4 with independent random wready per channel -> each channel emits its own sequence with no interference; start during RUN is ignored.
